// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with watermark flags and sticky overflow/underflow errors.
// Optional macro FIFO_COUNT_EN exposes the internal occupancy as fill_count.
module fifo_param #(
    parameter int unsigned DATA_SIZE       = 8,
    parameter int unsigned ADDR_SIZE       = 3,
    parameter int unsigned ALMOST_FULL_TH  = 6,
    parameter int unsigned ALMOST_EMPTY_TH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 err_overflow,
`ifdef FIFO_COUNT_EN
    output logic                 err_underflow,
    output logic [ADDR_SIZE:0]   fill_count
`else
    output logic                 err_underflow
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 err_overflow_q, err_overflow_d;
    logic                 err_underflow_q, err_underflow_d;
    logic                 push_acc;
    logic                 pop_acc;

    // Status flags decode straight from the registered count so none of them lags it.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
    assign almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_TH));

    // A full FIFO still takes a write when the same edge frees a slot.
    assign pop_acc  = read && !empty;
    assign push_acc = write && (!full || pop_acc);

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        data_out_d      = data_out_q;
        valid_out_d     = 1'b0;
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end
        if (pop_acc) begin
            rd_ptr_d    = rd_ptr_q + ADDR_SIZE'(1);
            data_out_d  = mem[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (write && !push_acc) begin
            err_overflow_d = 1'b1;
        end
        if (read && empty) begin
            err_underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            data_out_q      <= '0;
            valid_out_q     <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            data_out_q      <= data_out_d;
            valid_out_q     <= valid_out_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
`ifdef FIFO_COUNT_EN
    assign fill_count    = count_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: queue-based reference model checked every cycle plus literal spot checks.
module tb_fifo_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          valid_out, full, empty, almost_full, almost_empty;
    logic          err_overflow, err_underflow;
`ifdef FIFO_COUNT_EN
    logic [3:0]    fill_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fifo_param dut (
        .clk           (clk),
        .reset         (reset),
        .write         (write),
        .read          (read),
        .data_in       (data_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .err_overflow  (err_overflow),
`ifdef FIFO_COUNT_EN
        .err_underflow (err_underflow),
        .fill_count    (fill_count)
`else
        .err_underflow (err_underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus the architectural side-effects.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid, m_ovf, m_unf;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_dout  <= '0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
        end else begin
            bit do_pop, do_push;
            do_pop  = read && (q.size() > 0);
            do_push = write && ((q.size() < DEPTH) || do_pop);
            if (read && q.size() == 0) m_unf <= 1'b1;
            if (write && !do_push)     m_ovf <= 1'b1;
            m_valid <= do_pop;
            if (do_pop) m_dout <= q.pop_front();
            if (do_push) q.push_back(data_in);
        end
    end

    // Every-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (reset) begin
            chk("data_out",      32'(data_out),      32'(m_dout));
            chk("valid_out",     32'(valid_out),     32'(m_valid));
            chk("full",          32'(full),          32'(q.size() == DEPTH));
            chk("empty",         32'(empty),         32'(q.size() == 0));
            chk("almost_full",   32'(almost_full),   32'(q.size() >= 6));
            chk("almost_empty",  32'(almost_empty),  32'(q.size() <= 1));
            chk("err_overflow",  32'(err_overflow),  32'(m_ovf));
            chk("err_underflow", 32'(err_underflow), 32'(m_unf));
`ifdef FIFO_COUNT_EN
            chk("fill_count",    32'(fill_count),    32'(q.size()));
`endif
        end
    end

    // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        write   = w;
        read    = r;
        data_in = d;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"},   32'(empty),         32'd1);
        chk({tag, "_full"},    32'(full),          32'd0);
        chk({tag, "_aempty"},  32'(almost_empty),  32'd1);
        chk({tag, "_afull"},   32'(almost_full),   32'd0);
        chk({tag, "_dout"},    32'(data_out),      32'd0);
        chk({tag, "_valid"},   32'(valid_out),     32'd0);
        chk({tag, "_ovf"},     32'(err_overflow),  32'd0);
        chk({tag, "_unf"},     32'(err_underflow), 32'd0);
    endtask

    initial begin
        // Reset then idle
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        cyc(0, 0, 8'h00);
        chk_reset_vals("idle");

        // Fill and drain
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, DW'(i));
            if (i == 5) chk("afull_at5", 32'(almost_full), 32'd0);
            if (i == 6) chk("afull_at6", 32'(almost_full), 32'd1);
            if (i == 7) chk("full_at7",  32'(full),        32'd0);
        end
        chk("full_at8", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 8'h00);
            chk("drain_valid", 32'(valid_out), 32'd1);
            chk("drain_data",  32'(data_out),  32'(i));
        end
        cyc(0, 0, 8'h00);
        chk("drain_valid_off", 32'(valid_out), 32'd0);
        chk("drain_empty",     32'(empty),     32'd1);

        // Overflow: write while full is dropped
        for (int i = 1; i <= 8; i++) cyc(1, 0, DW'(i));
        cyc(1, 0, 8'hAA);
        chk("ovf_set", 32'(err_overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 8'h00);
            chk("ovf_data", 32'(data_out), 32'(i));
        end
        chk("ovf_sticky", 32'(err_overflow), 32'd1);
        chk("ovf_empty",  32'(empty),        32'd1);

        // Underflow: read+write on empty accepts only the write
        cyc(1, 1, 8'h55);
        chk("unf_set",    32'(err_underflow), 32'd1);
        chk("unf_valid",  32'(valid_out),     32'd0);
        chk("unf_cnt1",   32'(q.size()),      32'd1);
        chk("unf_nempty", 32'(empty),         32'd0);
        cyc(0, 1, 8'h00);
        chk("unf_data",   32'(data_out),      32'h55);
        chk("unf_vld",    32'(valid_out),     32'd1);
        cyc(0, 1, 8'h00);
        chk("unf_hold",   32'(data_out),      32'h55);
        chk("unf_sticky", 32'(err_underflow), 32'd1);

        // Wrap, then simultaneous read/write at count 6
        for (int i = 0; i < 5; i++) cyc(1, 0, DW'(8'h10 + i));
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 8'h00);
            chk("wrap_pop", 32'(data_out), 32'(8'h10 + i));
        end
        for (int i = 0; i < 6; i++) cyc(1, 0, DW'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, DW'(8'h20 + i));
            chk("sim_data",  32'(data_out),    (i < 6) ? 32'(8'h30 + i) : 32'(8'h20 + i - 6));
            chk("sim_afull", 32'(almost_full), 32'd1);
            chk("sim_full",  32'(full),        32'd0);
        end
        chk("sim_cnt6", 32'(q.size()), 32'd6);

        // Async reset mid-operation at count 4
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h00);
        write = 1'b0;
        read  = 1'b0;
        chk("pre_cnt4", 32'(q.size()), 32'd4);
`ifdef FIFO_COUNT_EN
        chk("pre_fill4", 32'(fill_count), 32'd4);
`endif
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
`ifdef FIFO_COUNT_EN
        chk("async_fill0", 32'(fill_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 0, 8'h77);
        chk("post_cnt", 32'(empty), 32'd0);
        cyc(0, 1, 8'h00);
        chk("post_data",  32'(data_out),  32'h77);
        chk("post_valid", 32'(valid_out), 32'd1);
        cyc(0, 0, 8'h00);
        chk("post_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO that supersedes the fixed 6x8 memory: internal write/read pointers, occupancy tracking, full/empty and programmable almost-full/almost-empty watermarks, plus sticky overflow/underflow error flags.
One instance buffers one virtual channel in the PCIe switching datapath. The switch arbiter reads the watermark flags to throttle upstream sources.
Width and depth are set per instance.

Parameters:
DATA_SIZE, 8, word width in bits
ADDR_SIZE, 3, pointer width; depth = 2**ADDR_SIZE (default 8 words)
ALMOST_FULL_TH, 6, almost_full asserts when count >= this value
ALMOST_EMPTY_TH, 1, almost_empty asserts when count <= this value

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
write  input  1  push request
read  input  1  pop request
data_in  input  DATA_SIZE  push data
data_out  output  DATA_SIZE  registered pop data
valid_out  output  1  data_out updated this cycle
full  output  1  count == depth
empty  output  1  count == 0
almost_full  output  1  watermark flag
almost_empty  output  1  watermark flag
err_overflow  output  1  sticky: write attempted while full and not accepted
err_underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (reset low, asynchronous):
  - pointers, count, data_out, valid_out, err_overflow and err_underflow go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (given default thresholds).
  - Memory contents are not cleared.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_SIZE bits and wrap naturally from depth-1 to 0.
  - count is ADDR_SIZE+1 bits, range 0..depth.
- Push accept = write && (!full || pop accept).
  - On accept: mem[wr_ptr] <= data_in and wr_ptr increments.
- Pop accept = read && !empty.
  - On accept: data_out <= mem[rd_ptr] and rd_ptr increments.
  - valid_out=1 on the cycle after the accepting edge (1-cycle read latency).
  - Otherwise valid_out=0 and data_out holds its last value.
- count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both or neither.
- Flags:
  - full, empty, almost_full and almost_empty are combinational from the registered count.
  - No flag lags count.
- Boundary cases:
  - Full, read and write together: both accepted, count stays at depth, no overflow.
  - Full, write only: write dropped, memory and pointers unchanged, err_overflow set.
  - Empty, read and write together: write accepted, read rejected, err_underflow set, valid_out=0 next cycle.
  - Empty, read only: err_underflow set, data_out unchanged.
- Error flags stay set until reset.
- Reset asserted mid-stream: all state returns to reset values immediately; queued words are lost (pointers zeroed).

Optional Feature:
FIFO_COUNT_EN
- Defined: adds output port fill_count [ADDR_SIZE:0], driven directly by the internal count register (reset 0). Used for arbiter weighting.
- Undefined: port absent; count stays internal; all other behaviour identical.

Test Plan:
- Reset then idle:
  - reset low for 2 cycles.
  - empty=1, full=0, almost_empty=1, data_out=0, valid_out=0, both error flags 0.
- Fill and drain:
  - push 8'h01..8'h08 on consecutive cycles.
  - full=1 after the 8th edge; almost_full rose after the 6th.
  - then 8 reads return 01..08 in order, each with valid_out one cycle after read; empty=1 at the end.
- Overflow:
  - with FIFO full, write 8'hAA.
  - err_overflow=1 and stays 1.
  - next 8 reads still return 01..08; AA never appears.
- Underflow:
  - with FIFO empty, read and write 8'h55 in the same cycle.
  - err_underflow=1, valid_out=0, count=1.
  - next read returns 8'h55.
- Wrap and simultaneous:
  - push 5 words, pop 5, then push 6 more so wr_ptr wraps past 7→0.
  - then hold read=write=1 for 10 cycles with an incrementing data_in.
  - count stays 6; output order is strictly FIFO.
- Async reset mid-operation:
  - assert reset between clock edges with count=4.
  - outputs return to reset values before the next edge.
  - after release, the first push/pop round-trips correctly.
  - with FIFO_COUNT_EN, fill_count reads 4 before the reset and 0 after.
